// File: rtl/router_2_outport_arbiter_if.sv
// Signal bundle between one output-port arbiter and the input FIFOs, flow
// control and crossbar it serves.
interface router_2_outport_arbiter_if;
  // Handshake: a flit moves from input X when Xgrant, Xreq and ready_in are
  // all high in the same cycle; Xpop is exactly that AND and is the FIFO read.
  logic       Lreq;
  logic       Nreq;
  logic       Ereq;
  logic       Ltail;
  logic       Ntail;
  logic       Etail;
  logic       ready_in;
  logic       Lgrant;
  logic       Ngrant;
  logic       Egrant;
  logic       Lpop;
  logic       Npop;
  logic       Epop;
  logic [1:0] sel;
  logic       busy;

  modport master (
    output Lreq, Nreq, Ereq,
    output Ltail, Ntail, Etail,
    output ready_in,
    input  Lgrant, Ngrant, Egrant,
    input  Lpop, Npop, Epop,
    input  sel, busy
  );

  modport slave (
    input  Lreq, Nreq, Ereq,
    input  Ltail, Ntail, Etail,
    input  ready_in,
    output Lgrant, Ngrant, Egrant,
    output Lpop, Npop, Epop,
    output sel, busy
  );
endinterface

// File: rtl/router_2_outport_arbiter.sv
// Round-robin wormhole arbiter sharing one router output port among the
// L, N and E input FIFOs; a grant is held from head flit to tail flit.
module router_2_outport_arbiter #(
  parameter int unsigned INIT_PTR = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  router_2_outport_arbiter_if.slave   port,
  output logic                        dbg_state,
  output logic [1:0]                  dbg_ptr
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic [1:0] SEL_NONE = 2'b11;
  localparam logic [1:0] PTR_RST  = 2'(INIT_PTR % 3);

  state_e     state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [1:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic [1:0] ptr_q, ptr_d;

  logic [2:0] req;
  logic [2:0] tail;
  logic [2:0] pop;
  logic       pick_valid;
  logic [1:0] pick_idx;
  logic [2:0] pick_oh;
  logic [2:0] cand_sum;
  logic [1:0] cand;
  logic       xfer;
  logic       xfer_tail;
  logic [1:0] ptr_after;

  // Bit order everywhere: [0] = L, [1] = N, [2] = E.
  assign req  = {port.Ereq,  port.Nreq,  port.Lreq};
  assign tail = {port.Etail, port.Ntail, port.Ltail};

  // First requester at or after ptr in cyclic order L -> N -> E -> L.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = ptr_q;
    cand_sum   = '0;
    cand       = '0;
    for (int off = 0; off < 3; off++) begin
      cand_sum = {1'b0, ptr_q} + 3'(off);
      cand     = (cand_sum >= 3'd3) ? 2'(cand_sum - 3'd3) : cand_sum[1:0];
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign pick_oh = pick_valid ? (3'b001 << pick_idx) : 3'b000;

  assign xfer      = (state_q == ST_GRANT) && (|(grant_q & req)) && port.ready_in;
  assign xfer_tail = xfer && (|(grant_q & tail));
  assign ptr_after = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_GRANT;
          grant_d = pick_oh;
          sel_d   = pick_idx;
          busy_d  = 1'b1;
        end
      end
      ST_GRANT: begin
        // Only a tail transfer ends the packet; an empty FIFO or stalled
        // downstream just holds the lock.
        if (xfer_tail) begin
          state_d = ST_IDLE;
          grant_d = 3'b000;
          sel_d   = SEL_NONE;
          busy_d  = 1'b0;
          ptr_d   = ptr_after;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= 3'b000;
      sel_q   <= SEL_NONE;
      busy_q  <= 1'b0;
      ptr_q   <= PTR_RST;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
    end
  end

  // Pops are the live read-enables; held off while reset is asserted.
  assign pop = grant_q & req & {3{port.ready_in & rst}};

  assign port.Lgrant = grant_q[0];
  assign port.Ngrant = grant_q[1];
  assign port.Egrant = grant_q[2];
  assign port.Lpop   = pop[0];
  assign port.Npop   = pop[1];
  assign port.Epop   = pop[2];
  assign port.sel    = sel_q;
  assign port.busy   = busy_q;

  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst)
    $onehot0(grant_q));

  a_pop_onehot: assert property (@(posedge clk) disable iff (!rst)
    $onehot0(pop));

  a_busy_tracks_grant: assert property (@(posedge clk) disable iff (!rst)
    busy_q == (grant_q != 3'b000));

  a_sel_tracks_grant: assert property (@(posedge clk) disable iff (!rst)
    (grant_q == 3'b000) == (sel_q == SEL_NONE));

  a_ptr_range: assert property (@(posedge clk) disable iff (!rst)
    ptr_q != 2'd3);

  a_hold_until_tail: assert property (@(posedge clk) disable iff (!rst)
    (state_q == ST_GRANT && !xfer_tail) |=> (grant_q == $past(grant_q)));

endmodule

// File: tb/tb_router_2_outport_arbiter.sv
// Bench for router_2_outport_arbiter: modelled input FIFOs, directed scenarios,
// random traffic and a queue-based scoreboard fed by a packet-level model.
module tb_router_2_outport_arbiter;

  localparam int INIT_PTR = 0;

  logic       clk;
  logic       rst;
  logic       dbg_state;
  logic [1:0] dbg_ptr;

  router_2_outport_arbiter_if bus();

  router_2_outport_arbiter #(.INIT_PTR(INIT_PTR)) dut (
    .clk       (clk),
    .rst       (rst),
    .port      (bus),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int pop_cnt[3];
  int glog_idx[$];
  int glog_cyc[$];
  logic prev_busy = 1'b0;

  // Expected transfers: {source[1:0], flit[7:0]}.
  logic [9:0] exp_q[$];

  // Input FIFO contents; flit = {src[1:0], seq[4:0], tail}.
  logic [7:0] l_q[$];
  logic [7:0] n_q[$];
  logic [7:0] e_q[$];
  logic [4:0] seq = '0;

  // Driver controls.
  logic       rst_v   = 1'b0;
  logic       ready_v = 1'b1;
  logic [2:0] gate_v  = 3'b000;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int s);
    case (s)
      0:       return l_q.size();
      1:       return n_q.size();
      default: return e_q.size();
    endcase
  endfunction

  function automatic logic [7:0] head(input int s);
    if (qsize(s) == 0) return 8'h00;
    case (s)
      0:       return l_q[0];
      1:       return n_q[0];
      default: return e_q[0];
    endcase
  endfunction

  task automatic qpop(input int s);
    logic [7:0] d;
    case (s)
      0:       d = l_q.pop_front();
      1:       d = n_q.pop_front();
      default: d = e_q.pop_front();
    endcase
  endtask

  task automatic load_pkt(input int s, input int len);
    logic [7:0] f;
    for (int i = 0; i < len; i++) begin
      f = {2'(s), seq, (i == len - 1) ? 1'b1 : 1'b0};
      seq++;
      case (s)
        0:       l_q.push_back(f);
        1:       n_q.push_back(f);
        default: e_q.push_back(f);
      endcase
    end
  endtask

  // ---------------- driver ----------------
  task automatic step();
    logic [7:0] h;
    @(negedge clk);
    rst          = rst_v;
    bus.ready_in = ready_v;
    h = head(0);
    bus.Lreq  = gate_v[0] && (qsize(0) > 0);
    bus.Ltail = bus.Lreq ? h[0] : 1'($urandom_range(0, 1));
    h = head(1);
    bus.Nreq  = gate_v[1] && (qsize(1) > 0);
    bus.Ntail = bus.Nreq ? h[0] : 1'($urandom_range(0, 1));
    h = head(2);
    bus.Ereq  = gate_v[2] && (qsize(2) > 0);
    bus.Etail = bus.Ereq ? h[0] : 1'($urandom_range(0, 1));
  endtask

  task automatic clear_counts();
    foreach (pop_cnt[i]) pop_cnt[i] = 0;
  endtask

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    while (!((qsize(0) == 0) && (qsize(1) == 0) && (qsize(2) == 0) && !bus.busy)
           && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) chk({name, "_timeout"}, 1, 0);
  endtask

  // ---------------- reference model ----------------
  // Packet-level view: which input owns the port (-1 = nobody) and whose
  // turn is next; the current-cycle outputs follow directly from that.
  int         m_owner = -1;
  int         m_ptr   = INIT_PTR;
  bit         m_valid = 1'b0;
  int         m_found;
  logic [2:0] m_req;
  logic [2:0] m_tail;
  logic [2:0] exp_grant;
  logic [1:0] exp_sel;
  logic       exp_busy;
  int         exp_ptr;
  bit         exp_valid = 1'b0;

  always @(negedge clk) begin
    #2;
    m_req     = {bus.Ereq,  bus.Nreq,  bus.Lreq};
    m_tail    = {bus.Etail, bus.Ntail, bus.Ltail};
    exp_valid = m_valid;
    exp_grant = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
    exp_sel   = (m_owner >= 0) ? 2'(m_owner) : 2'b11;
    exp_busy  = (m_owner >= 0);
    exp_ptr   = m_ptr;
    if (!rst) begin
      m_owner = -1;
      m_ptr   = INIT_PTR;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_owner < 0) begin
        m_found = -1;
        for (int k = 0; k < 3; k++) begin
          if (m_found < 0 && m_req[(m_ptr + k) % 3]) m_found = (m_ptr + k) % 3;
        end
        m_owner = m_found;
      end else if (m_req[m_owner] && bus.ready_in) begin
        exp_q.push_back({2'(m_owner), head(m_owner)});
        if (m_tail[m_owner]) begin
          m_ptr   = (m_owner + 1) % 3;
          m_owner = -1;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [2:0] dut_pop;
  logic [9:0] exp_e;

  always @(negedge clk) begin
    #3;
    dut_pop = {bus.Epop, bus.Npop, bus.Lpop};
    if (exp_valid) begin
      chk("grant", {bus.Egrant, bus.Ngrant, bus.Lgrant}, exp_grant);
      chk("sel",   bus.sel,   exp_sel);
      chk("busy",  bus.busy,  exp_busy);
      chk("state", dbg_state, exp_busy);
      chk("ptr",   dbg_ptr,   exp_ptr);
    end
    chk("pop_onehot", ($countones(dut_pop) <= 1) ? 1 : 0, 1);
    for (int i = 0; i < 3; i++) begin
      if (dut_pop[i]) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", i, -1);
        end else begin
          exp_e = exp_q.pop_front();
          chk("pop_flit", {2'(i), head(i)}, exp_e);
        end
        qpop(i);
        pop_cnt[i]++;
      end
    end
    chk("missed_pop", exp_q.size(), 0);
    exp_q.delete();
    if (exp_valid && bus.busy && !prev_busy) begin
      glog_idx.push_back(int'(bus.sel));
      glog_cyc.push_back(cycle);
    end
    prev_busy = bus.busy;
    cycle++;
  end

  // ---------------- stimulus ----------------
  int n;
  int exp_order[6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    rst = 1'b0;
    bus.ready_in = 1'b1;
    bus.Lreq = 1'b0; bus.Nreq = 1'b0; bus.Ereq = 1'b0;
    bus.Ltail = 1'b0; bus.Ntail = 1'b0; bus.Etail = 1'b0;
    clear_counts();

    // Reset, then idle.
    rst_v = 1'b0;
    repeat (2) step();
    rst_v = 1'b1;
    repeat (2) step();
    #1;
    chk("idle_sel",   bus.sel, 3);
    chk("idle_grant", {bus.Egrant, bus.Ngrant, bus.Lgrant}, 0);
    chk("idle_busy",  bus.busy, 0);

    // Single requester N, 3-flit packet.
    clear_counts();
    load_pkt(1, 3);
    gate_v = 3'b010;
    step();
    step();
    #1;
    chk("n_grant_latency", bus.Ngrant, 1);
    chk("n_sel", bus.sel, 1);
    drain(50, "single");
    chk("n_pops", pop_cnt[1], 3);
    chk("ptr_after_n", dbg_ptr, 2);
    chk("sel_after_n", bus.sel, 3);

    // Round-robin fairness from a fresh reset.
    rst_v = 1'b0;
    repeat (2) step();
    rst_v = 1'b1;
    for (int r = 0; r < 2; r++) begin
      load_pkt(0, 1);
      load_pkt(1, 1);
      load_pkt(2, 1);
    end
    gate_v  = 3'b111;
    ready_v = 1'b1;
    glog_idx.delete();
    glog_cyc.delete();
    drain(60, "fair");
    chk("fair_count", glog_idx.size(), 6);
    if (glog_idx.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("fair_order", glog_idx[i], exp_order[i]);
      for (int i = 1; i < 6; i++) chk("fair_gap", glog_cyc[i] - glog_cyc[i-1], 2);
    end

    // Backpressure on L mid-packet.
    clear_counts();
    load_pkt(0, 4);
    gate_v = 3'b001;
    repeat (3) step();
    ready_v = 1'b0;
    repeat (5) begin
      step();
      #1;
      chk("bp_hold", bus.Lgrant, 1);
      chk("bp_nopop", bus.Lpop, 0);
    end
    ready_v = 1'b1;
    drain(40, "bp");
    chk("bp_pops", pop_cnt[0], 4);

    // Starved FIFO: E holds the port while L waits.
    clear_counts();
    load_pkt(2, 4);
    gate_v = 3'b100;
    n = 0;
    while (pop_cnt[2] < 2 && n < 20) begin step(); n++; end
    chk("starve_start", pop_cnt[2], 2);
    load_pkt(0, 1);
    gate_v = 3'b001;
    repeat (3) begin
      step();
      #1;
      chk("starve_e_held", bus.Egrant, 1);
      chk("starve_l_wait", bus.Lgrant, 0);
      chk("starve_sel",    bus.sel, 2);
    end
    gate_v = 3'b101;
    n = 0;
    while (pop_cnt[2] < 4 && n < 20) begin step(); n++; end
    chk("starve_e_pops", pop_cnt[2], 4);
    chk("wrap_ptr", dbg_ptr, 0);
    chk("wrap_bubble", bus.Lgrant, 0);
    step();
    #1;
    chk("wrap_l_next", bus.Lgrant, 1);
    drain(30, "starve");

    // Reset in the middle of an N packet.
    clear_counts();
    load_pkt(1, 4);
    gate_v = 3'b010;
    n = 0;
    while (pop_cnt[1] < 1 && n < 20) begin step(); n++; end
    rst_v = 1'b0;
    step();
    rst_v = 1'b1;
    step();
    #1;
    chk("rst_grant", {bus.Egrant, bus.Ngrant, bus.Lgrant}, 0);
    chk("rst_sel",   bus.sel, 3);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_ptr",   dbg_ptr, INIT_PTR);
    chk("rst_pop",   {bus.Epop, bus.Npop, bus.Lpop}, 0);
    drain(40, "rst");

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        n = $urandom_range(0, 2);
        if (qsize(n) < 12) load_pkt(n, $urandom_range(1, 4));
      end
      gate_v  = {($urandom_range(0, 9) != 0), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 9) != 0)};
      ready_v = ($urandom_range(0, 3) != 0);
      rst_v   = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_v   = 1'b1;
    gate_v  = 3'b111;
    ready_v = 1'b1;
    drain(600, "random");
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
